// File: rtl/counter_8_pkg.sv
// Shared constants for the counter_8 block: counter width, segment patterns, decode helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W / SEG_W  - count and segment bus widths
//   cnt_t / seg_t  - matching packed types
//   SEG_0..SEG_7   - lit-low segment patterns, bit order {g,f,e,d,c,b,a}
//   seg_lookup()   - count -> lit-low pattern
package counter_8_pkg;

  localparam int CNT_W = 3;
  localparam int SEG_W = 7;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SEG_W-1:0] seg_t;

  // Patterns are stored in the common-anode form (0 = segment lit).
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;

  function automatic seg_t seg_lookup(input cnt_t value);
    seg_t pat;
    case (value)
      3'd0:    pat = SEG_0;
      3'd1:    pat = SEG_1;
      3'd2:    pat = SEG_2;
      3'd3:    pat = SEG_3;
      3'd4:    pat = SEG_4;
      3'd5:    pat = SEG_5;
      3'd6:    pat = SEG_6;
      default: pat = SEG_7;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/counter_8_if.sv
// Bundles the counter_8 output bus (count plus its segment pattern).
// Latency: n/a (wires only).
// Backpressure: none; the bus is a free-running status output.
//
// Signals:
//   q       - current count
//   display - segment pattern of q
// Modports: master drives the bus (counter side), slave observes it (display/consumer side).
interface counter_8_if;
  import counter_8_pkg::*;

  cnt_t q;
  seg_t display;

  modport master (output q, output display);
  modport slave  (input  q, input  display);

endinterface

// File: rtl/seg7_decoder.sv
// Seven-segment decoder for a 3-bit value.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   value   - 3-bit input value
//   pattern - 7-bit segment pattern {g,f,e,d,c,b,a}
// SEG_ACTIVE_LOW = 1 drives 0 to light a segment; 0 drives 1 to light it.
module seg7_decoder
  import counter_8_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  cnt_t value,
  output seg_t pattern
);

  seg_t lit_low;

  always_comb begin
    lit_low = seg_lookup(value);
  end

  // The table is stored lit-low; a common-cathode build just inverts it.
  assign pattern = SEG_ACTIVE_LOW ? lit_low : ~lit_low;

endmodule

// File: rtl/counter_8.sv
// Free-running modulo-8 up-counter with seven-segment display of the count.
// Latency: oQ is the register itself; oDisplay is a zero-cycle decode of oQ.
// Backpressure: none; counts on every CLK edge while out of reset.
//
// Ports:
//   CLK      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset, forces count to 0
//   oQ       - current count 0..7
//   oDisplay - segment pattern of oQ, {g,f,e,d,c,b,a}
module counter_8
  import counter_8_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK,
  input  logic             rst_n,
  output logic [CNT_W-1:0] oQ,
  output logic [SEG_W-1:0] oDisplay
);

  cnt_t count_q;

  // Wrap 7 -> 0 falls out of the 3-bit add; no carry is kept.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + cnt_t'(1);
    end
  end

  assign oQ = count_q;

  seg7_decoder #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_seg7_decoder (
    .value   (count_q),
    .pattern (oDisplay)
  );

endmodule

// File: tb/tb_counter_8.sv
// Self-checking bench for counter_8: both display polarities, reset, wrap, async reset.
// A behavioural model (edge count since reset, modulo 8) is compared every cycle,
// plus directed literal checks at the interesting points.
module tb_counter_8;

  logic clk;
  logic rst_n;

  counter_8_if bus_lo ();
  counter_8_if bus_hi ();

  counter_8 #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .CLK      (clk),
    .rst_n    (rst_n),
    .oQ       (bus_lo.q),
    .oDisplay (bus_lo.display)
  );

  counter_8 #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .CLK      (clk),
    .rst_n    (rst_n),
    .oQ       (bus_hi.q),
    .oDisplay (bus_hi.display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Common-anode segment table, straight from the display truth table.
  logic [6:0] seg_tbl [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  // Model: number of rising edges seen with reset high since the last reset, mod 8.
  int model_cnt = 0;
  always @(posedge clk) begin
    if (rst_n) model_cnt = (model_cnt + 1) % 8;
    else       model_cnt = 0;
  end
  always @(negedge rst_n) model_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [6:0] exp_lo;
    exp_lo = seg_tbl[model_cnt];
    check("model_q_lo",    {5'd0, bus_lo.q},       8'(model_cnt));
    check("model_disp_lo", {1'b0, bus_lo.display}, {1'b0, exp_lo});
    check("model_q_hi",    {5'd0, bus_hi.q},       8'(model_cnt));
    check("model_disp_hi", {1'b0, bus_hi.display}, {1'b0, ~exp_lo});
  end

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;

    // Power-up reset held for two cycles.
    edges(1);
    check("rst_q_c1",    {5'd0, bus_lo.q},       8'h00);
    check("rst_disp_c1", {1'b0, bus_lo.display}, 8'h40);
    edges(1);
    check("rst_q_c2",    {5'd0, bus_lo.q},       8'h00);
    check("rst_disp_c2", {1'b0, bus_lo.display}, 8'h40);
    check("pol_disp_0",  {1'b0, bus_hi.display}, 8'h3F);

    // Release between edges, then walk a full sequence.
    #2 rst_n = 1'b1;
    edges(1);
    check("first_q",    {5'd0, bus_lo.q},       8'h01);
    check("first_disp", {1'b0, bus_lo.display}, 8'h79);
    edges(2);
    check("q_3",        {5'd0, bus_lo.q},       8'h03);
    check("pol_disp_3", {1'b0, bus_hi.display}, 8'h4F);
    edges(4);
    check("q_7",        {5'd0, bus_lo.q},       8'h07);
    check("disp_7",     {1'b0, bus_lo.display}, 8'h78);
    edges(1);
    check("wrap_q",     {5'd0, bus_lo.q},       8'h00);
    check("wrap_disp",  {1'b0, bus_lo.display}, 8'h40);
    edges(1);
    check("post_wrap_q",    {5'd0, bus_lo.q},       8'h01);
    check("post_wrap_disp", {1'b0, bus_lo.display}, 8'h79);

    // Advance to 5, then assert reset between edges.
    edges(4);
    check("pre_async_q",    {5'd0, bus_lo.q},       8'h05);
    check("pre_async_disp", {1'b0, bus_lo.display}, 8'h12);
    #2 rst_n = 1'b0;
    #1;
    check("async_q",    {5'd0, bus_lo.q},       8'h00);
    check("async_disp", {1'b0, bus_lo.display}, 8'h40);
    check("async_q_hi", {5'd0, bus_hi.q},       8'h00);
    edges(3);
    check("hold_q",    {5'd0, bus_lo.q},       8'h00);
    check("hold_disp", {1'b0, bus_lo.display}, 8'h40);

    // Release and take one edge.
    #2 rst_n = 1'b1;
    edges(1);
    check("release_q",    {5'd0, bus_lo.q},       8'h01);
    check("release_disp", {1'b0, bus_lo.display}, 8'h79);
    edges(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_8.md
COUNTER_8 -- requirements
Module: counter_8

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1, meaning: 1 = segment lit by driving 0 (common anode); 0 = segment lit by driving 1.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion and release timing per REQ-013, active-low.
REQ-004 oQ  output  3  current count value, unsigned 0..7.
REQ-005 oDisplay  output  7  seven-segment pattern of oQ; bit order {g,f,e,d,c,b,a} (oDisplay[6]=g, oDisplay[0]=a).
REQ-006 No other ports.

Function
REQ-007 The block SHALL hold a 3-bit up-counter that increments by exactly 1 on every rising CLK edge while rst_n is high.
REQ-008 Counting SHALL wrap modulo 8: 7 -> 0 on the next edge, with no carry or flag output.
REQ-009 oQ SHALL be the registered count directly, with zero added latency: it is valid immediately after each edge.
REQ-010 oDisplay SHALL be a purely combinational decode of oQ: zero cycles of latency, no separate register.
REQ-011 With SEG_ACTIVE_LOW=1, oDisplay SHALL be: 0->0x40, 1->0x79, 2->0x24, 3->0x30, 4->0x19, 5->0x12, 6->0x02, 7->0x78.
REQ-012 With SEG_ACTIVE_LOW=0, oDisplay SHALL be the bitwise inverse of the REQ-011 value for the same count.

Reset
REQ-013 rst_n low SHALL force the count to 0 immediately, independent of CLK.
REQ-014 While rst_n is low, oQ SHALL be 0 and oDisplay SHALL be 0x40 (active-low build).
REQ-015 Reset mid-count SHALL discard the current value.
REQ-016 After rst_n rises, the first rising CLK edge SHALL produce count 1.
REQ-017 A clock edge coincident with rst_n low SHALL NOT increment the count.

Structure
REQ-018 Segment encodings (the eight patterns of REQ-011) and the counter width constant (3) SHALL live in a shared package, counter_8_pkg.
REQ-019 Decoding SHALL be one sub-module, seg7_decoder: 3-bit value input, 7-bit pattern output, SEG_ACTIVE_LOW parameter passed through.
REQ-020 counter_8 SHALL contain only the counter register and the seg7_decoder instance.
REQ-021 The design SHALL contain no latches and no combinational loops.
REQ-022 The design SHALL be fully synthesizable.

Verification
REQ-023 Power-up reset: rst_n=0 for two CLK cycles -> oQ=0 and oDisplay=0x40 throughout.
REQ-024 Full sequence: release reset, apply 8 edges -> oQ steps 1,2,...,7,0; oDisplay tracks REQ-011 after every edge.
REQ-025 Wrap: from oQ=7, one edge -> oQ=0 and oDisplay=0x40; the next edge -> oQ=1 and oDisplay=0x79.
REQ-026 Asynchronous reset: at oQ=5, pull rst_n low between edges -> oQ=0 before the next edge; hold low for 3 edges -> remains 0.
REQ-027 Reset release: raise rst_n, then apply one edge -> oQ=1 and oDisplay=0x79.
REQ-028 Polarity: with SEG_ACTIVE_LOW=0 and oQ=3 -> oDisplay=0x4F; with oQ=0 -> oDisplay=0x3F.
